// File: rtl/vga_pkg.sv
// Shared timing defaults, counter sizing helpers and the pattern mode encoding
// for the scrolling VGA test-pattern generator.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int totalOf(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // One spare code above the total so the sync end boundary always fits.
  function automatic int cntWidth(input int active, input int fp, input int sync, input int bp);
    return $clog2(totalOf(active, fp, sync, bp) + 1);
  endfunction

  localparam int H_TOTAL_DEF = totalOf(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = totalOf(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef enum logic [1:0] {
    MODE_HBARS   = 2'd0,
    MODE_VBARS   = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_WHITE   = 2'd3
  } mode_e;

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical position counters with raw (unregistered) sync, active
// and end-of-frame decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic                                                i_clk,
  input  logic                                                i_rst_n,
  output logic [cntWidth(H_ACTIVE, H_FP, H_SYNC, H_BP)-1:0]   o_hpos,
  output logic [cntWidth(V_ACTIVE, V_FP, V_SYNC, V_BP)-1:0]   o_vpos,
  output logic                                                o_hsyncRaw,
  output logic                                                o_vsyncRaw,
  output logic                                                o_active,
  output logic                                                o_lastPixel
);

  localparam int H_TOTAL = totalOf(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = totalOf(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_W     = cntWidth(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_W     = cntWidth(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic [H_W-1:0] r_hpos;
  logic [V_W-1:0] r_vpos;
  logic           w_hLast;
  logic           w_vLast;

  assign w_hLast = (r_hpos == H_W'(H_TOTAL - 1));
  assign w_vLast = (r_vpos == V_W'(V_TOTAL - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hpos <= '0;
      r_vpos <= '0;
    end else if (w_hLast) begin
      r_hpos <= '0;
      r_vpos <= w_vLast ? '0 : r_vpos + 1'b1;
    end else begin
      r_hpos <= r_hpos + 1'b1;
    end
  end

  assign o_hpos      = r_hpos;
  assign o_vpos      = r_vpos;
  assign o_hsyncRaw  = !((r_hpos >= H_W'(H_ACTIVE + H_FP)) &&
                         (r_hpos <  H_W'(H_ACTIVE + H_FP + H_SYNC)));
  assign o_vsyncRaw  = !((r_vpos >= V_W'(V_ACTIVE + V_FP)) &&
                         (r_vpos <  V_W'(V_ACTIVE + V_FP + V_SYNC)));
  assign o_active    = (r_hpos < H_W'(H_ACTIVE)) && (r_vpos < V_W'(V_ACTIVE));
  assign o_lastPixel = w_hLast && w_vLast;

endmodule

// File: rtl/vga_scroll_pattern.sv
// Scrolling bar / checkerboard / white test-pattern generator. Control inputs
// are shadowed once per frame so a frame is always drawn with one setting.
module vga_scroll_pattern
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_FP         = H_FP_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_BP         = H_BP_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int V_FP         = V_FP_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_BP         = V_BP_DEF,
  parameter int COLOR_BITS   = 2,
  parameter int SCROLL_W     = 10,
  parameter int STRIPE_SHIFT = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            i_mode,
  input  logic                  i_dir,
  input  logic [3:0]            i_speed,
  output logic [COLOR_BITS-1:0] o_r,
  output logic [COLOR_BITS-1:0] o_g,
  output logic [COLOR_BITS-1:0] o_b,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic                  o_frame_tick,
  output logic [8:0]            o_frame_no
);

  localparam int H_W = cntWidth(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_W = cntWidth(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic [H_W-1:0]        w_hpos;
  logic [V_W-1:0]        w_vpos;
  logic                  w_hsyncRaw;
  logic                  w_vsyncRaw;
  logic                  w_active;
  logic                  w_frameTick;
  logic [SCROLL_W-1:0]   w_xs;
  logic [SCROLL_W-1:0]   w_ys;
  logic [2:0]            w_colorIdx;

  mode_e                 r_mode;
  logic                  r_dir;
  logic [3:0]            r_speed;
  logic [SCROLL_W-1:0]   r_offset;
  logic [8:0]            r_frameNo;
  logic [COLOR_BITS-1:0] r_r;
  logic [COLOR_BITS-1:0] r_g;
  logic [COLOR_BITS-1:0] r_b;
  logic                  r_hsync;
  logic                  r_vsync;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) uTiming (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .o_hpos      (w_hpos),
    .o_vpos      (w_vpos),
    .o_hsyncRaw  (w_hsyncRaw),
    .o_vsyncRaw  (w_vsyncRaw),
    .o_active    (w_active),
    .o_lastPixel (w_frameTick)
  );

  // Offset steps with the settings in force for the frame just finished;
  // the new inputs are captured in the same edge for the next frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode    <= MODE_HBARS;
      r_dir     <= 1'b0;
      r_speed   <= '0;
      r_offset  <= '0;
      r_frameNo <= '0;
    end else if (w_frameTick) begin
      r_offset  <= r_dir ? r_offset - SCROLL_W'(r_speed) : r_offset + SCROLL_W'(r_speed);
      r_frameNo <= r_frameNo + 1'b1;
      r_mode    <= mode_e'(i_mode);
      r_dir     <= i_dir;
      r_speed   <= i_speed;
    end
  end

  assign w_xs = SCROLL_W'(w_hpos) + r_offset;
  assign w_ys = SCROLL_W'(w_vpos) + r_offset;

  always_comb begin
    w_colorIdx = 3'b111;
    unique case (r_mode)
      MODE_HBARS:   w_colorIdx = w_xs[STRIPE_SHIFT+2:STRIPE_SHIFT];
      MODE_VBARS:   w_colorIdx = w_ys[STRIPE_SHIFT+2:STRIPE_SHIFT];
      MODE_CHECKER: w_colorIdx = {3{w_hpos[STRIPE_SHIFT] ^ w_vpos[STRIPE_SHIFT]}};
      MODE_WHITE:   w_colorIdx = 3'b111;
    endcase
  end

  // Colour and sync share one register stage so they stay aligned.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_r     <= w_active ? {COLOR_BITS{w_colorIdx[0]}} : '0;
      r_g     <= w_active ? {COLOR_BITS{w_colorIdx[1]}} : '0;
      r_b     <= w_active ? {COLOR_BITS{w_colorIdx[2]}} : '0;
      r_hsync <= w_hsyncRaw;
      r_vsync <= w_vsyncRaw;
    end
  end

  assign o_r          = r_r;
  assign o_g          = r_g;
  assign o_b          = r_b;
  assign o_hsync      = r_hsync;
  assign o_vsync      = r_vsync;
  assign o_frame_tick = w_frameTick;
  assign o_frame_no   = r_frameNo;

endmodule

// File: tb/tb_vga_scroll_pattern.sv
// Scoreboard bench for vga_scroll_pattern using a shrunken raster so many
// frames fit in a short run; a frame-level model predicts every output cycle.
module tb_vga_scroll_pattern;

  localparam int HA = 64;
  localparam int HFP = 4;
  localparam int HS = 8;
  localparam int HB = 4;
  localparam int VA = 24;
  localparam int VFP = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int CB = 2;
  localparam int SW = 10;
  localparam int SS = 3;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct {
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
    logic       tick;
    logic [8:0] frameNo;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [1:0]    mode;
  logic          dir;
  logic [3:0]    speed;
  logic [CB-1:0] r;
  logic [CB-1:0] g;
  logic [CB-1:0] b;
  logic          hsync;
  logic          vsync;
  logic          frameTick;
  logic [8:0]    frameNo;

  int   compared = 0;
  int   mismatched = 0;
  int   sinceRelease = 0;
  exp_t expQ[$];

  // Model state: position within the frame plus the per-frame settings.
  int mCount = 0;
  int mOffset = 0;
  int mMode = 0;
  int mDir = 0;
  int mSpeed = 0;
  int mFrame = 0;

  vga_scroll_pattern #(
    .H_ACTIVE     (HA),
    .H_FP         (HFP),
    .H_SYNC       (HS),
    .H_BP         (HB),
    .V_ACTIVE     (VA),
    .V_FP         (VFP),
    .V_SYNC       (VS),
    .V_BP         (VB),
    .COLOR_BITS   (CB),
    .SCROLL_W     (SW),
    .STRIPE_SHIFT (SS)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_mode       (mode),
    .i_dir        (dir),
    .i_speed      (speed),
    .o_r          (r),
    .o_g          (g),
    .o_b          (b),
    .o_hsync      (hsync),
    .o_vsync      (vsync),
    .o_frame_tick (frameTick),
    .o_frame_no   (frameNo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t pixelOf(input int count, input int offset, input int m);
    exp_t p;
    int h, v, xs, ys, c;
    bit act;
    h   = count % HT;
    v   = count / HT;
    act = (h < HA) && (v < VA);
    xs  = (h + offset) % (1 << SW);
    ys  = (v + offset) % (1 << SW);
    case (m)
      0:       c = (xs >> SS) % 8;
      1:       c = (ys >> SS) % 8;
      2:       c = (((h >> SS) ^ (v >> SS)) & 1) ? 7 : 0;
      default: c = 7;
    endcase
    p.rgb = 6'd0;
    if (act) begin
      p.rgb[5:4] = (c & 1) ? 2'b11 : 2'b00;
      p.rgb[3:2] = (c & 2) ? 2'b11 : 2'b00;
      p.rgb[1:0] = (c & 4) ? 2'b11 : 2'b00;
    end
    p.hs      = !((h >= HA + HFP) && (h < HA + HFP + HS));
    p.vs      = !((v >= VA + VFP) && (v < VA + VFP + VS));
    p.tick    = 1'b0;
    p.frameNo = 9'd0;
    return p;
  endfunction

  task automatic checkOutput(input string name, input int got, input int expected);
    compared++;
    if (got !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input int d, input int s, input int cycles);
    mode  = 2'(m);
    dir   = 1'(d);
    speed = 4'(s);
    repeat (cycles) @(negedge clk);
    sinceRelease += cycles;
  endtask

  // Model: predict what the DUT registers at this edge and the state after it.
  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mCount = 0; mOffset = 0; mMode = 0; mDir = 0; mSpeed = 0; mFrame = 0;
      e.rgb = 6'd0; e.hs = 1'b1; e.vs = 1'b1;
    end else begin
      e = pixelOf(mCount, mOffset, mMode);
      if (mCount == FRAME - 1) begin
        mOffset = mDir ? (mOffset + (1 << SW) - mSpeed) % (1 << SW)
                       : (mOffset + mSpeed) % (1 << SW);
        mFrame  = (mFrame + 1) % 512;
        mMode   = int'(mode);
        mDir    = int'(dir);
        mSpeed  = int'(speed);
      end
      mCount = (mCount + 1) % FRAME;
    end
    e.tick    = (mCount == FRAME - 1);
    e.frameNo = 9'(mFrame);
    expQ.push_back(e);
  end

  // Monitor: compare the DUT against the oldest prediction just after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 1, 0);
    end else begin
      e = expQ.pop_front();
      checkOutput("rgb", int'({r, g, b}), int'(e.rgb));
      checkOutput("sync", int'({hsync, vsync}), int'({e.hs, e.vs}));
      checkOutput("frame_tick", int'(frameTick), int'(e.tick));
      checkOutput("frame_no", int'(frameNo), int'(e.frameNo));
    end
  end

  initial begin
    int left;
    int n;
    int waitCycles;
    rst_n = 1'b0;
    mode  = 2'd0;
    dir   = 1'b0;
    speed = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sinceRelease = 0;

    applyStimulus(0, 0, 3, 3 * FRAME);
    applyStimulus(1, 1, 15, 3 * FRAME);
    // Mode change part-way through a frame must only show up next frame.
    applyStimulus(0, 0, 0, FRAME + 10 * HT);
    applyStimulus(2, 0, 1, 2 * FRAME - 10 * HT);
    applyStimulus(3, 0, 0, 3 * FRAME);

    left = 5 * FRAME;
    while (left > 0) begin
      n = $urandom_range(50, 900);
      if (n > left) n = left;
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 15), n);
      left -= n;
    end

    // Land on a white active pixel, then pull reset mid-frame.
    applyStimulus(3, 0, 0, FRAME);
    waitCycles = ((10 * HT + 30) - (sinceRelease % FRAME) + FRAME) % FRAME;
    applyStimulus(3, 0, 0, waitCycles);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_rgb", int'({r, g, b}), 0);
    checkOutput("async_reset_hsync", int'(hsync), 1);
    checkOutput("async_reset_vsync", int'(vsync), 1);
    checkOutput("async_reset_frame_no", int'(frameNo), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sinceRelease = 0;
    applyStimulus(3, 0, 0, 2 * FRAME + 100);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
